// File: rtl/pretrigger_delay_line_if.sv
// Sample/config/output bundle for the pretrigger delay line.
// The capture side drives din/hold/size_config; the delay line returns the delayed word.
interface pretrigger_delay_line_if #(
  parameter int P_ADDR_WIDTH = 5,
  parameter int P_DATA_WIDTH = 22
);
  logic [P_DATA_WIDTH-1:0] din;
  logic                    hold;
  logic [P_ADDR_WIDTH-1:0] size_config;
  logic [P_DATA_WIDTH-1:0] ptb_out;
  logic                    rdy;
  logic [P_ADDR_WIDTH-1:0] d_active;

  modport master (
    output din, hold, size_config,
    input  ptb_out, rdy, d_active
  );

  modport slave (
    input  din, hold, size_config,
    output ptb_out, rdy, d_active
  );
endinterface

// File: rtl/pretrigger_delay_line.sv
// Runtime-configurable fixed-latency delay line for packed ADC/discriminator sample words.
// RAM write at p0, synchronous RAM read lands in p1, masked output register is p2.
module pretrigger_delay_line #(
  parameter int P_ADDR_WIDTH = 5,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_MIN_DELAY  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pretrigger_delay_line_if.slave bus
);
  localparam int DEPTH = 1 << P_ADDR_WIDTH;
  localparam int CNT_W = P_ADDR_WIDTH + 1;
  localparam logic [P_ADDR_WIDTH-1:0] MIN_D   = P_ADDR_WIDTH'(P_MIN_DELAY);
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  function automatic logic [P_ADDR_WIDTH-1:0] clip_delay(input logic [P_ADDR_WIDTH-1:0] req);
    return (req < MIN_D) ? MIN_D : req;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [P_DATA_WIDTH-1:0] mem [DEPTH];
  logic [P_ADDR_WIDTH-1:0] wr_ptr_p0;
  logic [P_ADDR_WIDTH-1:0] rd_addr_p0;
  logic [P_ADDR_WIDTH-1:0] d_req_p0;
  logic [P_ADDR_WIDTH-1:0] d_active_q;
  logic [CNT_W-1:0]        epoch_cnt;
  logic                    apply_p0;
  logic [P_DATA_WIDTH-1:0] rd_data_p1;
  logic                    vld_p1;
  logic [P_DATA_WIDTH-1:0] ptb_p2;
  logic                    vld_p2;

  // p0: clip the request, detect a config apply, and aim the read D-1 slots behind the write.
  // The read feeds an output register, so one slot of the delay is spent there; this also
  // keeps read and write addresses apart for every legal delay, including the maximum.
  always_comb begin
    d_req_p0   = clip_delay(bus.size_config);
    apply_p0   = (d_req_p0 != d_active_q);
    rd_addr_p0 = wr_ptr_p0 - (d_active_q - P_ADDR_WIDTH'(1));
    // After this edge the epoch count becomes cnt+1; sample 1 shows once that reaches D+1.
    vld_p1     = !apply_p0 && (epoch_cnt >= {1'b0, d_active_q});
  end

  // p0 -> p1: storage, no reset needed since nothing stale leaves the masked output.
  always_ff @(posedge clk) begin
    if (!bus.hold) begin
      mem[wr_ptr_p0] <= bus.din;
      rd_data_p1     <= mem[rd_addr_p0];
    end
  end

  // p1 -> p2: control state and the zero-masked output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p0  <= '0;
      epoch_cnt  <= '0;
      d_active_q <= MIN_D;
      vld_p2     <= 1'b0;
      ptb_p2     <= '0;
    end else if (!bus.hold) begin
      wr_ptr_p0 <= wr_ptr_p0 + P_ADDR_WIDTH'(1);
      if (apply_p0) begin
        d_active_q <= d_req_p0;
        epoch_cnt  <= CNT_W'(1);
      end else begin
        epoch_cnt  <= sat_inc(epoch_cnt);
      end
      vld_p2 <= vld_p1;
      ptb_p2 <= vld_p1 ? rd_data_p1 : '0;
    end
  end

  assign bus.ptb_out  = ptb_p2;
  assign bus.rdy      = vld_p2;
  assign bus.d_active = d_active_q;
endmodule

// File: tb/tb_pretrigger_delay_line.sv
// Bench for pretrigger_delay_line: directed scenarios on the (5,22) build plus a
// randomized sweep over three parameter sets against an epoch/sample-number model.
module tb_pretrigger_delay_line;
  localparam int MIN_D = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pretrigger_delay_line_if #(.P_ADDR_WIDTH(4), .P_DATA_WIDTH(8))  bus0 ();
  pretrigger_delay_line_if #(.P_ADDR_WIDTH(5), .P_DATA_WIDTH(22)) bus1 ();
  pretrigger_delay_line_if #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(40)) bus2 ();

  pretrigger_delay_line #(.P_ADDR_WIDTH(4), .P_DATA_WIDTH(8), .P_MIN_DELAY(3))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  pretrigger_delay_line #(.P_ADDR_WIDTH(5), .P_DATA_WIDTH(22), .P_MIN_DELAY(3))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  pretrigger_delay_line #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(40), .P_MIN_DELAY(3))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  // Reference model: per epoch, sample k (k-th active edge) is due after edge k + D.
  int          m_d    [3];
  longint      m_n    [3];
  logic [63:0] m_hist [3][256];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_d[i] = MIN_D;
      m_n[i] = 0;
    end
  endfunction

  function automatic void model_edge(int i, logic [63:0] din, int cfg);
    int dreq;
    dreq = (cfg < MIN_D) ? MIN_D : cfg;
    if (dreq != m_d[i]) begin
      m_d[i] = dreq;
      m_n[i] = 0;
    end
    m_n[i] = m_n[i] + 1;
    m_hist[i][int'(m_n[i] % 256)] = din;
  endfunction

  function automatic logic model_rdy(int i);
    return m_n[i] >= longint'(m_d[i] + 1);
  endfunction

  function automatic logic [63:0] model_out(int i);
    if (!model_rdy(i)) return 64'd0;
    return m_hist[i][int'((m_n[i] - longint'(m_d[i])) % 256)];
  endfunction

  function automatic logic [63:0] dut_out(int i);
    case (i)
      0:       return 64'(bus0.ptb_out);
      1:       return 64'(bus1.ptb_out);
      default: return 64'(bus2.ptb_out);
    endcase
  endfunction

  function automatic logic dut_rdy(int i);
    case (i)
      0:       return bus0.rdy;
      1:       return bus1.rdy;
      default: return bus2.rdy;
    endcase
  endfunction

  function automatic int dut_d(int i);
    case (i)
      0:       return int'(bus0.d_active);
      1:       return int'(bus1.d_active);
      default: return int'(bus2.d_active);
    endcase
  endfunction

  function automatic logic [63:0] dut_din(int i);
    case (i)
      0:       return 64'(bus0.din);
      1:       return 64'(bus1.din);
      default: return 64'(bus2.din);
    endcase
  endfunction

  function automatic logic dut_hold(int i);
    case (i)
      0:       return bus0.hold;
      1:       return bus1.hold;
      default: return bus2.hold;
    endcase
  endfunction

  function automatic int dut_cfg(int i);
    case (i)
      0:       return int'(bus0.size_config);
      1:       return int'(bus1.size_config);
      default: return int'(bus2.size_config);
    endcase
  endfunction

  // One clock edge; the model follows every instance that saw an active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n)
      for (int i = 0; i < 3; i++)
        if (!dut_hold(i)) model_edge(i, dut_din(i), dut_cfg(i));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus1.size_config = 5'd5;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_out(i) !== 64'd0) begin
        errors++; $display("FAIL reset_ptb_out[%0d]: got %0h want 0", i, dut_out(i));
      end
      checks++;
      if (dut_rdy(i) !== 1'b0) begin
        errors++; $display("FAIL reset_rdy[%0d]: got %0b want 0", i, dut_rdy(i));
      end
      checks++;
      if (dut_d(i) != MIN_D) begin
        errors++; $display("FAIL reset_d_active[%0d]: got %0d want %0d", i, dut_d(i), MIN_D);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_delay();
    int exp;
    do_reset();
    bus1.size_config = 5'd5;
    for (int k = 1; k <= 1000; k++) begin
      bus1.din = 22'(k);
      tick();
      exp = (k >= 6) ? k - 5 : 0;
      checks++;
      if (bus1.rdy !== (k >= 6)) begin
        errors++; $display("FAIL basic_rdy edge %0d: got %0b want %0b", k, bus1.rdy, (k >= 6));
      end
      checks++;
      if (bus1.ptb_out !== 22'(exp)) begin
        errors++; $display("FAIL basic_ptb edge %0d: got %0d want %0d", k, bus1.ptb_out, exp);
      end
      if (k == 1) begin
        checks++;
        if (bus1.d_active !== 5'd5) begin
          errors++; $display("FAIL basic_d_active: got %0d want 5", bus1.d_active);
        end
      end
    end
  endtask

  task automatic test_clip_max();
    int cfgs [4];
    int d;
    logic [21:0] rec [1:128];
    cfgs = '{0, 1, 2, 31};
    for (int t = 0; t < 4; t++) begin
      d = (cfgs[t] < MIN_D) ? MIN_D : cfgs[t];
      do_reset();
      bus1.size_config = 5'(cfgs[t]);
      for (int k = 1; k <= d + 70; k++) begin
        rec[k]   = 22'($urandom);
        bus1.din = rec[k];
        tick();
        checks++;
        if (int'(bus1.d_active) != d) begin
          errors++; $display("FAIL clip_d_active cfg %0d: got %0d want %0d", cfgs[t], bus1.d_active, d);
        end
        checks++;
        if (bus1.rdy !== (k >= d + 1)) begin
          errors++; $display("FAIL clip_rdy cfg %0d edge %0d: got %0b want %0b", cfgs[t], k, bus1.rdy, (k >= d + 1));
        end
        checks++;
        if (bus1.ptb_out !== ((k >= d + 1) ? rec[k - d] : 22'd0)) begin
          errors++; $display("FAIL clip_ptb cfg %0d edge %0d: got %0h want %0h", cfgs[t], k, bus1.ptb_out,
                             ((k >= d + 1) ? rec[k - d] : 22'd0));
        end
      end
    end
  endtask

  task automatic test_config_change();
    do_reset();
    bus1.size_config = 5'd5;
    for (int k = 1; k <= 210; k++) begin
      bus1.din = 22'(k);
      if (k == 100) bus1.size_config = 5'd9;
      if (k == 200) bus1.size_config = 5'd4;
      tick();
      checks++;
      if (bus1.ptb_out !== 22'(model_out(1)) || bus1.rdy !== model_rdy(1)) begin
        errors++; $display("FAIL cfg_model edge %0d: got %0d/%0b want %0d/%0b", k, bus1.ptb_out, bus1.rdy,
                           model_out(1), model_rdy(1));
      end
      if (k == 100 || k == 200) begin
        checks++;
        if (bus1.rdy !== 1'b0 || int'(bus1.d_active) != ((k == 100) ? 9 : 4)) begin
          errors++; $display("FAIL cfg_apply edge %0d: got rdy=%0b d=%0d want rdy=0 d=%0d", k, bus1.rdy,
                             bus1.d_active, ((k == 100) ? 9 : 4));
        end
      end
      if (k == 108 || k == 203) begin
        checks++;
        if (bus1.rdy !== 1'b0) begin
          errors++; $display("FAIL cfg_blind edge %0d: got rdy=%0b want 0", k, bus1.rdy);
        end
      end
      if (k == 109 || k == 204) begin
        checks++;
        if (bus1.rdy !== 1'b1 || bus1.ptb_out !== ((k == 109) ? 22'd100 : 22'd200)) begin
          errors++; $display("FAIL cfg_first_sample edge %0d: got rdy=%0b ptb=%0d want rdy=1 ptb=%0d", k,
                             bus1.rdy, bus1.ptb_out, ((k == 109) ? 100 : 200));
        end
      end
    end
  endtask

  task automatic test_hold();
    int dcnt;
    int exp;
    logic hold_now;
    logic [21:0] prev_ptb;
    logic        prev_rdy;
    logic [4:0]  prev_d;
    dcnt = 0;
    do_reset();
    bus1.size_config = 5'd5;
    prev_ptb = bus1.ptb_out;
    prev_rdy = bus1.rdy;
    prev_d   = bus1.d_active;
    for (int c = 0; c < 60; c++) begin
      hold_now  = (c >= 20 && c < 27) || (c >= 40 && c < 47);
      bus1.hold = hold_now;
      if (c == 42) bus1.size_config = 5'd7;
      if (!hold_now) begin
        dcnt++;
        bus1.din = 22'(dcnt);
      end else begin
        bus1.din = 22'($urandom);
      end
      tick();
      if (hold_now) begin
        checks++;
        if (bus1.ptb_out !== prev_ptb || bus1.rdy !== prev_rdy || bus1.d_active !== prev_d) begin
          errors++; $display("FAIL hold_frozen cycle %0d: got %0d/%0b/%0d want %0d/%0b/%0d", c, bus1.ptb_out,
                             bus1.rdy, bus1.d_active, prev_ptb, prev_rdy, prev_d);
        end
      end else if (c < 40) begin
        exp = (dcnt >= 6) ? dcnt - 5 : 0;
        checks++;
        if (bus1.ptb_out !== 22'(exp) || bus1.rdy !== (dcnt >= 6)) begin
          errors++; $display("FAIL hold_stream cycle %0d: got %0d/%0b want %0d/%0b", c, bus1.ptb_out, bus1.rdy,
                             exp, (dcnt >= 6));
        end
      end
      if (c == 47) begin
        checks++;
        if (bus1.d_active !== 5'd7 || bus1.rdy !== 1'b0) begin
          errors++; $display("FAIL hold_cfg_apply: got d=%0d rdy=%0b want d=7 rdy=0", bus1.d_active, bus1.rdy);
        end
      end
      checks++;
      if (bus1.ptb_out !== 22'(model_out(1)) || bus1.rdy !== model_rdy(1) || int'(bus1.d_active) != m_d[1]) begin
        errors++; $display("FAIL hold_model cycle %0d: got %0d/%0b/%0d want %0d/%0b/%0d", c, bus1.ptb_out,
                           bus1.rdy, bus1.d_active, model_out(1), model_rdy(1), m_d[1]);
      end
      prev_ptb = bus1.ptb_out;
      prev_rdy = bus1.rdy;
      prev_d   = bus1.d_active;
    end
    bus1.hold = 1'b0;
  endtask

  task automatic test_async_reset();
    int exp;
    do_reset();
    bus1.size_config = 5'd5;
    for (int k = 1; k <= 20; k++) begin
      bus1.din = 22'(k);
      tick();
    end
    checks++;
    if (bus1.rdy !== 1'b1) begin
      errors++; $display("FAIL arst_precondition_rdy: got %0b want 1", bus1.rdy);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (bus1.ptb_out !== 22'd0 || bus1.rdy !== 1'b0 || bus1.d_active !== 5'd3) begin
      errors++; $display("FAIL arst_clear: got %0d/%0b/%0d want 0/0/3", bus1.ptb_out, bus1.rdy, bus1.d_active);
    end
    bus1.din = 22'd1;
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      bus1.din = 22'(k);
      tick();
      exp = (k >= 6) ? k - 5 : 0;
      checks++;
      if (bus1.ptb_out !== 22'(exp) || bus1.rdy !== (k >= 6)) begin
        errors++; $display("FAIL arst_repeat edge %0d: got %0d/%0b want %0d/%0b", k, bus1.ptb_out, bus1.rdy,
                           exp, (k >= 6));
      end
    end
  endtask

  task automatic test_sweep();
    bus0.size_config = 4'd10;
    bus1.size_config = 5'd20;
    bus2.size_config = 8'd200;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus0.hold = ($urandom_range(0, 5) == 0);
      bus1.hold = ($urandom_range(0, 5) == 0);
      bus2.hold = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0)  bus0.size_config = 4'($urandom);
      if ($urandom_range(0, 59) == 0)  bus1.size_config = 5'($urandom);
      if ($urandom_range(0, 399) == 0) bus2.size_config = 8'($urandom);
      bus0.din = 8'($urandom);
      bus1.din = 22'($urandom);
      bus2.din = 40'({$urandom(), $urandom()});
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dut_out(i) !== model_out(i) || dut_rdy(i) !== model_rdy(i) || dut_d(i) != m_d[i]) begin
          errors++; $display("FAIL sweep[%0d] cycle %0d: got %0h/%0b/%0d want %0h/%0b/%0d", i, cyc, dut_out(i),
                             dut_rdy(i), dut_d(i), model_out(i), model_rdy(i), m_d[i]);
        end
      end
    end
    bus0.hold = 1'b0;
    bus1.hold = 1'b0;
    bus2.hold = 1'b0;
  endtask

  initial begin
    bus0.din = '0; bus0.hold = 1'b0; bus0.size_config = 4'd3;
    bus1.din = '0; bus1.hold = 1'b0; bus1.size_config = 5'd3;
    bus2.din = '0; bus2.hold = 1'b0; bus2.size_config = 8'd3;
    model_reset();
    test_reset();
    test_basic_delay();
    test_clip_max();
    test_config_change();
    test_hold();
    test_async_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
